// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile of lane vectors, then streams it unskewed followed by LANES-1 zero drain vectors.
// Optional macro SYSTOLIC_FEEDER_REPLAY_EN keeps the tile after each stream and adds a discard input.
module systolic_feeder #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   start,
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
  input  logic                   discard,
`endif
  output logic                   tile_ready,
  output logic [CW-1:0]          tile_len,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_flush,
  output logic                   out_last,
  output logic                   busy
);
  localparam int LW = LANES * WIDTH;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(LANES + 1);
  typedef enum logic [1:0] {LOAD, HOLD, STREAM, FLUSH} state_t;
  state_t        r_state;
  logic [LW-1:0] r_buf [DEPTH];
  logic [CW-1:0] r_wr, r_rd, r_len;
  logic [FW-1:0] r_fcnt;
  logic          r_tile_ready, r_out_valid, r_out_flush, r_out_last, r_busy;
  logic [LW-1:0] r_out_data;
  logic          w_accept, w_close, w_stream_done, w_flush_done, w_end, w_discard;
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
  assign w_discard = discard;
`else
  localparam bit REPLAY = 1'b0;
  assign w_discard = 1'b0;
`endif
  assign w_accept      = in_valid && r_state == LOAD;
  assign w_close       = in_last || r_wr == CW'(DEPTH - 1);
  assign w_stream_done = r_rd == r_len;
  assign w_flush_done  = r_fcnt == FW'(LANES - 1);
  // With one lane there is no drain phase, so the sequence ends straight out of STREAM.
  assign w_end = (r_state == STREAM && w_stream_done && LANES == 1) ||
                 (r_state == FLUSH && w_flush_done);
  assign in_ready   = r_state == LOAD;
  assign tile_ready = r_tile_ready;
  assign tile_len   = r_len;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_flush  = r_out_flush;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[AW'(r_wr)] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOAD;
      r_wr         <= '0;
      r_rd         <= '0;
      r_len        <= '0;
      r_fcnt       <= '0;
      r_tile_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_flush  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flush <= 1'b0;
      r_out_last  <= 1'b0;
      case (r_state)
        LOAD: if (w_accept) begin
          r_wr <= r_wr + CW'(1);
          if (w_close) begin
            r_len        <= r_wr + CW'(1);
            r_state      <= HOLD;
            r_tile_ready <= 1'b1;
          end
        end
        HOLD: if (w_discard) begin
          r_state      <= LOAD;
          r_wr         <= '0;
          r_len        <= '0;
          r_tile_ready <= 1'b0;
        end else if (start) begin
          r_state      <= STREAM;
          r_tile_ready <= 1'b0;
          r_busy       <= 1'b1;
          r_rd         <= CW'(1);
          r_out_valid  <= 1'b1;
          r_out_data   <= r_buf[0];
          r_out_last   <= LANES == 1 && r_len == CW'(1);
        end
        STREAM: if (!w_stream_done) begin
          r_rd        <= r_rd + CW'(1);
          r_out_valid <= 1'b1;
          r_out_data  <= r_buf[AW'(r_rd)];
          r_out_last  <= LANES == 1 && r_rd + CW'(1) == r_len;
        end else if (LANES > 1) begin
          r_state     <= FLUSH;
          r_fcnt      <= FW'(1);
          r_out_valid <= 1'b1;
          r_out_flush <= 1'b1;
          r_out_last  <= LANES == 2;
        end
        FLUSH: if (!w_flush_done) begin
          r_fcnt      <= r_fcnt + FW'(1);
          r_out_valid <= 1'b1;
          r_out_flush <= 1'b1;
          r_out_last  <= r_fcnt + FW'(1) == FW'(LANES - 1);
        end
        default: r_state <= LOAD;
      endcase
      if (w_end) begin
        r_state      <= REPLAY ? HOLD : LOAD;
        r_busy       <= 1'b0;
        r_fcnt       <= '0;
        r_tile_ready <= REPLAY;
        if (!REPLAY) begin
          r_wr  <= '0;
          r_len <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed scenario tests for systolic_feeder (WIDTH=16, LANES=4, DEPTH=8).
module tb_systolic_feeder;
  localparam int LW = 64;
  logic          clk = 1'b0;
  logic          reset, in_valid, in_last, start, discard;
  logic [LW-1:0] in_data;
  logic          in_ready, tile_ready, out_valid, out_flush, out_last, busy;
  logic [3:0]    tile_len;
  logic [LW-1:0] out_data;
  int            n_checks = 0;
  int            n_fail = 0;
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif
  systolic_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .start(start),
`ifdef SYSTOLIC_FEEDER_REPLAY_EN
    .discard(discard),
`endif
    .tile_ready(tile_ready), .tile_len(tile_len), .out_valid(out_valid),
    .out_data(out_data), .out_flush(out_flush), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [LW-1:0] mk(input int k);
    logic [15:0] b;
    b = 16'(k * 16);
    return {b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input logic [LW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic load_tile(input int n, input int base);
    for (int i = 0; i < n; i++) send_beat(mk(base + i), i == n - 1);
  endtask
  task automatic run_stream(input int n, input int base, input string tag, input bit poke_start);
    logic [LW-1:0] exp_d;
    n_checks++;
    if (tile_ready !== 1'b1 || tile_len !== 4'(n)) begin
      n_fail++;
      $display("FAIL %s pre-start tile_ready/tile_len: got %b/%0d want 1/%0d", tag, tile_ready, tile_len, n);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n + 3; i++) begin
      exp_d = i < n ? mk(base + i) : '0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_flush !== (i >= n) ||
          out_last !== (i == n + 2) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got v=%b d=%h f=%b l=%b b=%b want v=1 d=%h f=%b l=%b b=1",
                 tag, i, out_valid, out_data, out_flush, out_last, busy, exp_d, i >= n, i == n + 2);
      end
      if (poke_start && i == 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_flush !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        in_ready !== !REPLAY || tile_ready !== REPLAY || tile_len !== (REPLAY ? 4'(n) : 4'd0)) begin
      n_fail++;
      $display("FAIL %s post-sequence: got v=%b d=%h f=%b l=%b b=%b ir=%b tr=%b len=%0d want v=0 d=0 f=0 l=0 b=0 ir=%b tr=%b len=%0d",
               tag, out_valid, out_data, out_flush, out_last, busy, in_ready, tile_ready, tile_len,
               !REPLAY, REPLAY, REPLAY ? n : 0);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || tile_ready !== 1'b0 || tile_len !== 4'd0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_flush !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got ir=%b tr=%b len=%0d v=%b d=%h f=%b l=%b b=%b want ir=1 tr=0 len=0 v=0 d=0 f=0 l=0 b=0",
               in_ready, tile_ready, tile_len, out_valid, out_data, out_flush, out_last, busy);
    end
    reset = 1'b0;
  endtask
  task automatic test_basic_tile();
    load_tile(3, 0);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic hold: got in_ready=%b busy=%b want 0/0", in_ready, busy);
    end
    run_stream(3, 0, "basic", 1'b0);
    if (REPLAY) begin
      discard = 1'b1;
      step();
      discard = 1'b0;
    end
  endtask
  task automatic test_auto_close();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (in_ready !== (k < 8)) begin
        n_fail++;
        $display("FAIL auto_close in_ready beat %0d: got %b want %b", k, in_ready, k < 8);
      end
      send_beat(mk(40 + k), 1'b0);
    end
    run_stream(8, 40, "auto_close", 1'b0);
    if (REPLAY) begin
      discard = 1'b1;
      step();
      discard = 1'b0;
    end
  endtask
  task automatic test_valid_toggle();
    send_beat(mk(60), 1'b1);
    step();
    send_beat(mk(99), 1'b1);
    step();
    run_stream(1, 60, "toggle", 1'b0);
    if (REPLAY) begin
      discard = 1'b1;
      step();
      discard = 1'b0;
    end
  endtask
  task automatic test_start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_load: got ir=%b v=%b b=%b want 1/0/0", in_ready, out_valid, busy);
    end
    load_tile(3, 80);
    run_stream(3, 80, "start_ignored", 1'b1);
    if (REPLAY) begin
      discard = 1'b1;
      step();
      discard = 1'b0;
    end
  endtask
  task automatic test_reset_mid_stream();
    load_tile(5, 100);
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== mk(100)) begin
      n_fail++;
      $display("FAIL midreset first vector: got v=%b d=%h want 1/%h", out_valid, out_data, mk(100));
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || tile_ready !== 1'b0 ||
        busy !== 1'b0 || tile_len !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset: got v=%b d=%h ir=%b tr=%b b=%b len=%0d want 0/0/1/0/0/0",
               out_valid, out_data, in_ready, tile_ready, busy, tile_len);
    end
    load_tile(2, 120);
    run_stream(2, 120, "after_reset", 1'b0);
  endtask
  task automatic test_replay();
    if (REPLAY) begin
      discard = 1'b1;
      step();
      discard = 1'b0;
      load_tile(2, 140);
      run_stream(2, 140, "replay1", 1'b0);
      run_stream(2, 140, "replay2", 1'b0);
      discard = 1'b1;
      step();
      discard = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || tile_ready !== 1'b0 || tile_len !== 4'd0) begin
        n_fail++;
        $display("FAIL discard: got ir=%b tr=%b len=%0d want 1/0/0", in_ready, tile_ready, tile_len);
      end
      load_tile(2, 160);
      start = 1'b1;
      discard = 1'b1;
      step();
      start = 1'b0;
      discard = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || tile_len !== 4'd0) begin
        n_fail++;
        $display("FAIL start+discard: got ir=%b v=%b b=%b len=%0d want 1/0/0/0", in_ready, out_valid, busy, tile_len);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL start+discard no stream: got v=%b want 0", out_valid);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    start = 1'b0;
    discard = 1'b0;
    test_reset();
    test_basic_tile();
    test_auto_close();
    test_valid_toggle();
    test_start_ignored();
    test_reset_mid_stream();
    test_replay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
